// File: rtl/fetch_group_tx.sv
// rtl/fetch_group_tx.sv - fetch-group transmitter: slot masks, predicted next-PCs, group FIFO toward the instruction buffer
package config_pkg;
    typedef struct packed {
        int unsigned INSTR_PER_FETCH;
        int unsigned ILEN;
        int unsigned PLEN;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{INSTR_PER_FETCH: 4, ILEN: 32, PLEN: 32};
endpackage

module fetch_group_tx #(
    parameter config_pkg::cfg_t Cfg      = config_pkg::EmptyCfg,
    parameter int unsigned      FQ_DEPTH = 4
) (
    input  logic                                           clk_i,
    input  logic                                           rst_i,
    input  logic                                           resp_valid_i,
    output logic                                           resp_ready_o,
    input  logic [Cfg.INSTR_PER_FETCH*Cfg.ILEN-1:0]        resp_instrs_i,
    input  logic [Cfg.PLEN-1:0]                            resp_pc_i,
    input  logic                                           resp_pred_taken_i,
    input  logic [$clog2(Cfg.INSTR_PER_FETCH)-1:0]         resp_pred_slot_i,
    input  logic [Cfg.PLEN-1:0]                            resp_pred_target_i,
    output logic                                           fe_valid_o,
    input  logic                                           fe_ready_i,
    output logic [Cfg.INSTR_PER_FETCH*Cfg.ILEN-1:0]        fe_instrs_o,
    output logic [Cfg.PLEN-1:0]                            fe_pc_o,
    output logic [Cfg.INSTR_PER_FETCH-1:0]                 fe_slot_valid_o,
    output logic [Cfg.INSTR_PER_FETCH*Cfg.PLEN-1:0]        fe_pred_npc_o,
    input  logic                                           flush_i
);
    localparam int unsigned W    = Cfg.INSTR_PER_FETCH;
    localparam int unsigned ILEN = Cfg.ILEN;
    localparam int unsigned PLEN = Cfg.PLEN;
    localparam int unsigned IB   = ILEN / 8;
    localparam int unsigned GB   = $clog2(W * IB);
    localparam int unsigned IBB  = $clog2(IB);
    localparam int unsigned SW   = $clog2(W);
    localparam int unsigned PW   = $clog2(FQ_DEPTH);
    localparam int unsigned CW   = $clog2(FQ_DEPTH + 1);

    if (FQ_DEPTH < 2 || (FQ_DEPTH & (FQ_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "fetch_group_tx: FQ_DEPTH must be a power of two >= 2");
    end

    logic [PLEN-1:0]     base;
    logic [SW-1:0]       off;
    logic                tk;
    logic [W-1:0]        slot_valid;
    logic [W*PLEN-1:0]   pred_npc;
    logic                unused_pc_lsb;

    assign base          = {resp_pc_i[PLEN-1:GB], {GB{1'b0}}};
    assign off           = resp_pc_i[GB-1:IBB];
    assign unused_pc_lsb = ^resp_pc_i[IBB-1:0];
    // A prediction on a slot before the entry point cannot be the branch we jump through.
    assign tk            = resp_pred_taken_i && (resp_pred_slot_i >= off);

    always_comb begin
        slot_valid = '0;
        pred_npc   = '0;
        for (int i = 0; i < int'(W); i++) begin
            slot_valid[i] = (SW'(i) >= off) && (!tk || SW'(i) <= resp_pred_slot_i);
            if (tk && SW'(i) == resp_pred_slot_i) begin
                pred_npc[i*PLEN +: PLEN] = resp_pred_target_i;
            end else begin
                pred_npc[i*PLEN +: PLEN] = base + PLEN'((i + 1) * int'(IB));
            end
        end
    end

    logic [W*ILEN-1:0] fq_instrs     [FQ_DEPTH];
    logic [PLEN-1:0]   fq_pc         [FQ_DEPTH];
    logic [W-1:0]      fq_slot_valid [FQ_DEPTH];
    logic [W*PLEN-1:0] fq_pred_npc   [FQ_DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    // No pass-through when full keeps fe_ready_i off the resp_ready_o path.
    assign resp_ready_o = !flush_i && (count < CW'(FQ_DEPTH));
    assign fe_valid_o   = !flush_i && (count != '0);
    assign push         = resp_valid_i && resp_ready_o;
    assign pop          = fe_valid_o && fe_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fq_instrs[wr_ptr]     <= resp_instrs_i;
            fq_pc[wr_ptr]         <= base;
            fq_slot_valid[wr_ptr] <= slot_valid;
            fq_pred_npc[wr_ptr]   <= pred_npc;
        end
    end

    assign fe_instrs_o     = fq_instrs[rd_ptr];
    assign fe_pc_o         = fq_pc[rd_ptr];
    assign fe_slot_valid_o = fq_slot_valid[rd_ptr];
    assign fe_pred_npc_o   = fq_pred_npc[rd_ptr];
endmodule

// File: tb/tb_fetch_group_tx.sv
// tb/tb_fetch_group_tx.sv - self-checking bench for fetch_group_tx against a queue-based reference model
module tb_fetch_group_tx;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         resp_valid = 1'b0;
    logic         resp_ready;
    logic [127:0] resp_instrs = '0;
    logic [31:0]  resp_pc = '0;
    logic         resp_pred_taken = 1'b0;
    logic [1:0]   resp_pred_slot = '0;
    logic [31:0]  resp_pred_target = '0;
    logic         fe_valid;
    logic         fe_ready = 1'b0;
    logic [127:0] fe_instrs;
    logic [31:0]  fe_pc;
    logic [3:0]   fe_slot_valid;
    logic [127:0] fe_pred_npc;
    logic         flush = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [127:0] instrs;
        logic [31:0]  pc;
        logic [3:0]   sv;
        logic [127:0] npc;
    } grp_t;

    grp_t exp_q[$];

    fetch_group_tx dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .resp_valid_i       (resp_valid),
        .resp_ready_o       (resp_ready),
        .resp_instrs_i      (resp_instrs),
        .resp_pc_i          (resp_pc),
        .resp_pred_taken_i  (resp_pred_taken),
        .resp_pred_slot_i   (resp_pred_slot),
        .resp_pred_target_i (resp_pred_target),
        .fe_valid_o         (fe_valid),
        .fe_ready_i         (fe_ready),
        .fe_instrs_o        (fe_instrs),
        .fe_pc_o            (fe_pc),
        .fe_slot_valid_o    (fe_slot_valid),
        .fe_pred_npc_o      (fe_pred_npc),
        .flush_i            (flush)
    );

    always #5 clk = ~clk;

    // 16-byte groups of four 4-byte instructions.
    function automatic grp_t model(input logic [127:0] ins, input logic [31:0] pc, input logic taken,
                                   input logic [1:0] slot, input logic [31:0] tgt);
        grp_t g;
        int   off;
        bit   t;
        logic [31:0] base;
        off      = int'(pc % 32'd16) / 4;
        base     = pc - (pc % 32'd16);
        t        = taken && (int'(slot) >= off);
        g.instrs = ins;
        g.pc     = base;
        g.sv     = '0;
        g.npc    = '0;
        for (int i = 0; i < 4; i++) begin
            g.sv[i] = (i >= off) && (!t || i <= int'(slot));
            g.npc[32*i +: 32] = (t && i == int'(slot)) ? tgt : base + 32'(4 * (i + 1));
        end
        return g;
    endfunction

    task automatic tick();
        grp_t g;
        bit   push, pop;
        g    = model(resp_instrs, resp_pc, resp_pred_taken, resp_pred_slot, resp_pred_target);
        push = resp_valid && !flush && exp_q.size() < 4;
        pop  = !flush && exp_q.size() != 0 && fe_ready;
        @(posedge clk);
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            if (pop) exp_q.delete(0);
            if (push) exp_q.push_back(g);
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic tk,
                         input logic [1:0] slot, input logic [31:0] tgt);
        resp_valid       = v;
        resp_instrs      = {$urandom, $urandom, $urandom, $urandom};
        resp_pc          = pc;
        resp_pred_taken  = tk;
        resp_pred_slot   = slot;
        resp_pred_target = tgt;
    endtask

    task automatic drive_rand(input logic v);
        drive(v, $urandom, 1'($urandom), 2'($urandom), $urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_chk++; if (fe_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fe_valid: got %b want 0", fe_valid); end
        n_chk++; if (resp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_resp_ready: got %b want 1", resp_ready); end
    endtask

    task automatic test_slot_masks();
        logic [127:0] sent;
        fe_ready = 1'b0;
        drive(1'b1, 32'h8000_0008, 1'b0, 2'd0, 32'h0);
        sent = resp_instrs;
        #1;
        n_chk++; if (resp_ready !== 1'b1) begin n_fail++; $display("FAIL mask_ready: got %b want 1", resp_ready); end
        n_chk++; if (fe_valid !== 1'b0) begin n_fail++; $display("FAIL mask_latency: got %b want 0", fe_valid); end
        tick();
        resp_valid = 1'b0;
        #1;
        n_chk++; if (fe_valid !== 1'b1) begin n_fail++; $display("FAIL mask_valid: got %b want 1", fe_valid); end
        n_chk++; if (fe_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL mask_pc: got %h want 80000000", fe_pc); end
        n_chk++; if (fe_slot_valid !== 4'b1100) begin n_fail++; $display("FAIL mask_sv: got %b want 1100", fe_slot_valid); end
        n_chk++; if (fe_pred_npc[95:64] !== 32'h8000_000C) begin n_fail++; $display("FAIL mask_npc2: got %h want 8000000c", fe_pred_npc[95:64]); end
        n_chk++; if (fe_pred_npc[127:96] !== 32'h8000_0010) begin n_fail++; $display("FAIL mask_npc3: got %h want 80000010", fe_pred_npc[127:96]); end
        n_chk++; if (fe_instrs !== sent) begin n_fail++; $display("FAIL mask_instrs: got %h want %h", fe_instrs, sent); end
        fe_ready = 1'b1;
        tick();
        fe_ready = 1'b0;

        drive(1'b1, 32'h8000_0000, 1'b1, 2'd2, 32'h8000_0100);
        tick();
        resp_valid = 1'b0;
        #1;
        n_chk++; if (fe_slot_valid !== 4'b0111) begin n_fail++; $display("FAIL taken_sv: got %b want 0111", fe_slot_valid); end
        n_chk++; if (fe_pred_npc[95:64] !== 32'h8000_0100) begin n_fail++; $display("FAIL taken_npc2: got %h want 80000100", fe_pred_npc[95:64]); end
        n_chk++; if (fe_pred_npc[63:32] !== 32'h8000_0008) begin n_fail++; $display("FAIL taken_npc1: got %h want 80000008", fe_pred_npc[63:32]); end
        fe_ready = 1'b1;
        tick();
        fe_ready = 1'b0;

        drive(1'b1, 32'h8000_000C, 1'b1, 2'd2, 32'h8000_0100);
        tick();
        resp_valid = 1'b0;
        #1;
        n_chk++; if (fe_slot_valid !== 4'b1000) begin n_fail++; $display("FAIL ignored_sv: got %b want 1000", fe_slot_valid); end
        n_chk++; if (fe_pred_npc[127:96] !== 32'h8000_0010) begin n_fail++; $display("FAIL ignored_npc3: got %h want 80000010", fe_pred_npc[127:96]); end
        fe_ready = 1'b1;
        tick();
        fe_ready = 1'b0;

        drive(1'b1, 32'hFFFF_FFF4, 1'b0, 2'd0, 32'h0);
        tick();
        resp_valid = 1'b0;
        #1;
        n_chk++; if (fe_pred_npc[127:96] !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_npc3: got %h want 00000000", fe_pred_npc[127:96]); end
        n_chk++; if (fe_slot_valid !== 4'b1110) begin n_fail++; $display("FAIL wrap_sv: got %b want 1110", fe_slot_valid); end
        fe_ready = 1'b1;
        tick();
        fe_ready = 1'b0;
    endtask

    task automatic test_full();
        bit want;
        fe_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_rand(1'b1);
            #1;
            want = (k < 4);
            n_chk++; if (resp_ready !== want) begin n_fail++; $display("FAIL full_ready[%0d]: got %b want %b", k, resp_ready, want); end
            tick();
        end
        resp_valid = 1'b0;
        fe_ready   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            want = (k != 0);
            n_chk++; if (resp_ready !== want) begin n_fail++; $display("FAIL drain_ready[%0d]: got %b want %b", k, resp_ready, want); end
            n_chk++; if (fe_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b want 1", k, fe_valid); end
            if (exp_q.size() != 0) begin
                n_chk++;
                if ({fe_instrs, fe_pc, fe_slot_valid, fe_pred_npc} !== {exp_q[0].instrs, exp_q[0].pc, exp_q[0].sv, exp_q[0].npc}) begin
                    n_fail++; $display("FAIL drain_order[%0d]: got pc %h sv %b want pc %h sv %b", k, fe_pc, fe_slot_valid, exp_q[0].pc, exp_q[0].sv);
                end
            end
            tick();
        end
        #1;
        n_chk++; if (fe_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b want 0", fe_valid); end
    endtask

    task automatic test_back_to_back();
        fe_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            if (k < 10) drive_rand(1'b1); else resp_valid = 1'b0;
            #1;
            n_chk++; if (resp_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, resp_ready); end
            if (k > 0 && exp_q.size() != 0) begin
                n_chk++;
                if (fe_valid !== 1'b1 || {fe_instrs, fe_pc, fe_slot_valid, fe_pred_npc} !== {exp_q[0].instrs, exp_q[0].pc, exp_q[0].sv, exp_q[0].npc}) begin
                    n_fail++; $display("FAIL b2b_head[%0d]: got v %b pc %h want v 1 pc %h", k, fe_valid, fe_pc, exp_q[0].pc);
                end
            end
            tick();
        end
        #1;
        n_chk++; if (fe_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b want 0", fe_valid); end
    endtask

    task automatic test_flush();
        logic [31:0] want_pc;
        fe_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_rand(1'b1);
            tick();
        end
        drive_rand(1'b1);
        flush = 1'b1;
        #1;
        n_chk++; if (fe_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", fe_valid); end
        n_chk++; if (resp_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", resp_ready); end
        tick();
        flush      = 1'b0;
        resp_valid = 1'b0;
        #1;
        n_chk++; if (fe_valid !== 1'b0) begin n_fail++; $display("FAIL postflush_valid: got %b want 0", fe_valid); end
        n_chk++; if (resp_ready !== 1'b1) begin n_fail++; $display("FAIL postflush_ready: got %b want 1", resp_ready); end
        drive(1'b1, 32'h1234_5678, 1'b0, 2'd0, 32'h0);
        want_pc = 32'h1234_5670;
        tick();
        resp_valid = 1'b0;
        #1;
        n_chk++; if (fe_valid !== 1'b1 || fe_pc !== want_pc) begin n_fail++; $display("FAIL flush_resume: got v %b pc %h want v 1 pc %h", fe_valid, fe_pc, want_pc); end
        fe_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        fe_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive_rand(1'b1);
            tick();
        end
        resp_valid = 1'b0;
        fe_ready   = 1'b1;
        rst        = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_chk++; if (fe_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", fe_valid); end
        n_chk++; if (resp_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", resp_ready); end
        tick();
        #1;
        n_chk++; if (fe_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_empty: got %b want 0", fe_valid); end
    endtask

    task automatic test_random();
        bit ev, er;
        for (int c = 0; c < 400; c++) begin
            drive_rand(1'($urandom_range(0, 3) != 0));
            fe_ready = 1'($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 29) == 0);
            #1;
            ev = !flush && exp_q.size() != 0;
            er = !flush && exp_q.size() < 4;
            n_chk++; if (fe_valid !== ev) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, fe_valid, ev); end
            n_chk++; if (resp_ready !== er) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, resp_ready, er); end
            if (ev) begin
                n_chk++;
                if ({fe_instrs, fe_pc, fe_slot_valid, fe_pred_npc} !== {exp_q[0].instrs, exp_q[0].pc, exp_q[0].sv, exp_q[0].npc}) begin
                    n_fail++;
                    $display("FAIL rnd_payload[%0d]: got pc %h sv %b npc %h want pc %h sv %b npc %h", c,
                             fe_pc, fe_slot_valid, fe_pred_npc, exp_q[0].pc, exp_q[0].sv, exp_q[0].npc);
                end
            end
            tick();
        end
        flush      = 1'b0;
        resp_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_slot_masks();
        test_full();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_group_tx.md
Name: fetch_group_tx

Overview:
Frontend-side transmitter for the fetch-group interface consumed by the instruction buffer (fe_valid/fe_ready, fe_instrs, fe_pc, fe_slot_valid, fe_pred_npc). It accepts raw ICache/BPU responses and computes per-slot valid masks and predicted next-PCs. Groups are held in a small group-granular FIFO and presented to the instruction buffer in order. Backend flush clears all buffered groups.

Parameters:
Cfg, config_pkg::EmptyCfg, global config; supplies INSTR_PER_FETCH (W), ILEN, PLEN.
FQ_DEPTH, 4, buffered fetch groups; must be a power of two ≥2, otherwise $fatal at elaboration.

Ports:
clk_i  input  1  clock
rst_i  input  1  reset; synchronous, active-high
resp_valid_i  input  1  fetch response valid
resp_ready_o  output  1  transmitter can accept the response
resp_instrs_i  input  W*ILEN  instruction words for group-aligned slots 0..W-1
resp_pc_i  input  PLEN  PC of the first requested instruction (may be mid-group)
resp_pred_taken_i  input  1  BPU predicts a taken branch in this group
resp_pred_slot_i  input  $clog2(W)  slot index of the predicted-taken instruction
resp_pred_target_i  input  PLEN  predicted target
fe_valid_o  output  1  fetch group valid toward the instruction buffer
fe_ready_i  input  1  instruction buffer accepts the group
fe_instrs_o  output  W*ILEN  instructions
fe_pc_o  output  PLEN  PC of slot 0 (group-aligned)
fe_slot_valid_o  output  W  per-slot valid
fe_pred_npc_o  output  W*PLEN  per-slot predicted next PC
flush_i  input  1  backend flush

Behaviour:
- Group size G = W*ILEN/8 bytes. base = resp_pc_i with the low $clog2(G) bits cleared. off = resp_pc_i[$clog2(G)-1:$clog2(ILEN/8)].
- Taken slot: tk = resp_pred_taken_i && (resp_pred_slot_i >= off). If resp_pred_slot_i < off, the prediction is ignored and the group is treated as not-taken.
- slot_valid[i] = (i >= off) && (!tk || i <= resp_pred_slot_i).
- pred_npc[i] = resp_pred_target_i when tk and i == resp_pred_slot_i; otherwise base + (i+1)*(ILEN/8). Computed for every slot, including invalid ones, using PLEN-bit wrapping arithmetic.
- Enqueue: all values are computed at accept time and stored with the instructions and base in entry wr_ptr.
- FIFO: wr_ptr/rd_ptr are $clog2(FQ_DEPTH) bits and wrap naturally; count is $clog2(FQ_DEPTH+1) bits.
- resp_ready_o = !flush_i && (count < FQ_DEPTH). There is no same-cycle pass-through when full, so there is no combinational path from fe_ready_i to resp_ready_o.
- fe_valid_o = !flush_i && (count != 0). Outputs are read combinationally from entry rd_ptr.
- Push occurs when resp_valid_i && resp_ready_o. Pop occurs when fe_valid_o && fe_ready_i. Simultaneous push and pop leaves count unchanged; both pointers advance.
- Latency: a response accepted in cycle N is visible on fe_* in cycle N+1 at the earliest, or later if older groups are queued.
- Ordering: strict FIFO. Once fe_valid_o is asserted, fe_* payload is held stable until popped or flushed.
- flush_i, highest priority after reset:
  - Pointers and count go to 0 in the next cycle; any push or pop in that cycle is discarded.
  - fe_valid_o and resp_ready_o are 0 combinationally during the flush cycle.
  - Acceptance resumes the following cycle.
- Reset (rst_i=1 at posedge): pointers and count go to 0, same as flush. This is legal mid-operation; buffered groups are lost.
  - Output reset values: fe_valid_o=0, resp_ready_o=1 once rst_i is deasserted.
  - fe_* payload is don't-care while fe_valid_o=0; storage is not reset.
- Empty: fe_valid_o=0. Full: resp_ready_o=0. A pop while full frees one entry, and resp_ready_o rises in the next cycle.

Test Plan:
- W=4, ILEN=32, PLEN=32. Response pc=0x8000_0008, no prediction; accepted cycle 0 -> cycle 1: fe_valid_o=1, fe_pc_o=0x8000_0000, fe_slot_valid_o=4'b1100, pred_npc[2]=0x8000_000C, pred_npc[3]=0x8000_0010.
- pc=0x8000_0000, taken at slot 2, target 0x8000_0100 -> slot_valid=4'b0111, pred_npc[2]=0x8000_0100, pred_npc[1]=0x8000_0008. Same prediction with pc=0x8000_000C (off=3) -> prediction ignored, slot_valid=4'b1000, pred_npc[3]=0x8000_0010.
- fe_ready_i=0, 5 back-to-back responses -> first 4 accepted, resp_ready_o=0 on the 5th. Then fe_ready_i=1 -> groups emerge in order, one per cycle; resp_ready_o=1 one cycle after the first pop.
- Continuous push/pop with fe_ready_i=1 for 10 groups -> count stays 1, no loss or reordering, pointers wrap correctly.
- 3 groups buffered, flush_i pulsed for 1 cycle with resp_valid_i=1 -> that push is dropped; fe_valid_o=0 in the flush cycle and the next; new groups are accepted after the flush.
- rst_i asserted for 1 cycle with 2 groups buffered and fe_ready_i=1 -> fe_valid_o=0 the next cycle, count=0, resp_ready_o=1.
